// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the instruction sequencer and its environment:
// program load port, start command, processor issue/return signals and status.
// slave  : seen from the sequencer.
// master : seen from whoever drives the sequencer (host / processor side).
interface instr_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [23:0]       load_data;
  logic              start;
  logic              proc_ready;
  logic [7:0]        proc_result;
  logic [3:0]        proc_flags;
  logic [7:0]        opcode;
  logic [7:0]        operand1;
  logic [7:0]        operand2;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic [7:0]        last_result;
  logic [3:0]        last_flags;
  logic [ADDR_W:0]   retired;
  logic              timeout_err;

  modport slave (
    input  load_en, load_addr, load_data, start,
    input  proc_ready, proc_result, proc_flags,
    output opcode, operand1, operand2, pc, busy, done,
    output last_result, last_flags, retired, timeout_err
  );

  modport master (
    output load_en, load_addr, load_data, start,
    output proc_ready, proc_result, proc_flags,
    input  opcode, operand1, operand2, pc, busy, done,
    input  last_result, last_flags, retired, timeout_err
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer in front of the processor core. Holds a loadable
// {opcode, operand1, operand2} memory, issues one word at a time, waits for
// the processor's ready, retires result/flags, stops on HALT_OP or at the
// last address.
// Optional feature macro: SEQ_TIMEOUT_EN -- aborts a WAIT that lasts TIMEOUT
// cycles without an accepted ready and raises the sticky timeout_err.
module instr_sequencer #(
  parameter int         DEPTH   = 16,
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 15,
  parameter logic [7:0] HALT_OP = 8'hFF
) (
  input logic            clk,
  input logic            reset,
  instr_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_RETIRE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [23:0]       r_mem [DEPTH];
  logic [7:0]        r_opcode;
  logic [7:0]        r_operand1;
  logic [7:0]        r_operand2;
  logic [ADDR_W-1:0] r_pc;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_last_result;
  logic [3:0]        r_last_flags;
  logic [ADDR_W:0]   r_retired;
  logic              r_timeout_err;
  // Counts WAIT cycles; zero marks the first WAIT cycle whose ready is stale.
  logic [CNT_W-1:0]  r_wait_cnt;

  logic              w_can_cmd;
  logic [23:0]       w_word;
  logic              w_accept;
  logic              w_last_addr;
  logic              w_expire;

  assign w_can_cmd   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_word      = r_mem[r_pc];
  assign w_accept    = (r_wait_cnt != '0) && bus.proc_ready;
  assign w_last_addr = (r_pc == ADDR_W'(DEPTH - 1));

`ifdef SEQ_TIMEOUT_EN
  // Last allowed WAIT cycle: counter value TIMEOUT-1 is the TIMEOUT-th cycle.
  assign w_expire = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_expire = 1'b0;
`endif

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.load_en && w_can_cmd) begin
      r_mem[bus.load_addr] <= bus.load_data;
    end
  end

  // Sequencer FSM with all outputs held in registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_opcode      <= '0;
      r_operand1    <= '0;
      r_operand2    <= '0;
      r_pc          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_last_result <= '0;
      r_last_flags  <= '0;
      r_retired     <= '0;
      r_timeout_err <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_pc          <= '0;
            r_retired     <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_word[23:16] == HALT_OP) begin
            // HALT is never issued; operand outputs keep the previous word.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_opcode   <= w_word[23:16];
            r_operand1 <= w_word[15:8];
            r_operand2 <= w_word[7:0];
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
          if (w_accept) begin
            r_last_result <= bus.proc_result;
            r_last_flags  <= bus.proc_flags;
            r_state       <= S_RETIRE;
          end else if (w_expire) begin
            // Abort without retiring; pc keeps the failing address.
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end
        end
        S_RETIRE: begin
          r_retired <= r_retired + 1'b1;
          if (w_last_addr) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_pc    <= r_pc + 1'b1;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.opcode      = r_opcode;
  assign bus.operand1    = r_operand1;
  assign bus.operand2    = r_operand2;
  assign bus.pc          = r_pc;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.last_result = r_last_result;
  assign bus.last_flags  = r_last_flags;
  assign bus.retired     = r_retired;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed program table, hand-written corner
// sequences (reset mid-run, commands during WAIT, load+start together,
// full memory, optional timeout) and randomized programs with random
// processor ready, all checked against a program-level reference model.
module tb_instr_sequencer;

  localparam logic [7:0] HALT = 8'hFF;
  localparam int         BOUND = 2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  logic [23:0] prog [16];     // shadow of what the bench believes is in memory
  logic [7:0]  m_res = 8'h00; // model of last_result
  logic [3:0]  m_flg = 4'h0;  // model of last_flags

  instr_sequencer_if #(.ADDR_W(4)) bus ();

  instr_sequencer #(
    .DEPTH(16), .ADDR_W(4), .TIMEOUT(15), .HALT_OP(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Processor model: opcode 01 adds, anything else xors all three fields.
  function automatic logic [7:0] res_f(input logic [23:0] w);
    if (w[23:16] == 8'h01) return w[15:8] + w[7:0];
    return w[15:8] ^ w[7:0] ^ w[23:16];
  endfunction

  function automatic logic [3:0] flg_f(input logic [23:0] w);
    logic [7:0] r;
    r = res_f(w);
    return {(r == 8'h00), r[7], w[23:22]};
  endfunction

  assign bus.proc_result = res_f({bus.opcode, bus.operand1, bus.operand2});
  assign bus.proc_flags  = flg_f({bus.opcode, bus.operand1, bus.operand2});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_opcode",   32'(bus.opcode), 0);
    chk("rst_operand1", 32'(bus.operand1), 0);
    chk("rst_operand2", 32'(bus.operand2), 0);
    chk("rst_pc",       32'(bus.pc), 0);
    chk("rst_busy",     32'(bus.busy), 0);
    chk("rst_done",     32'(bus.done), 0);
    chk("rst_result",   32'(bus.last_result), 0);
    chk("rst_flags",    32'(bus.last_flags), 0);
    chk("rst_retired",  32'(bus.retired), 0);
    chk("rst_timeout",  32'(bus.timeout_err), 0);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic load_word(input int a, input logic [23:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = 4'(a);
    bus.load_data = d;
    prog[a]       = d;
    @(negedge clk);
    bus.load_en   = 1'b0;
  endtask

  // Runs the program from address 0 and checks every retirement against the
  // shadow program and the final status against the model.
  // mode: 0 ready always high, 1 random ready, 2 ready low until cycle 8,
  //       3 ready never high. poke: cycle at which start/load_en are pulsed
  //       with a bogus write (0 = none).
  task automatic run(input int mode, input int poke, input int exp_cyc,
                     input bit ld, input int ld_a, input logic [23:0] ld_d,
                     input bit exp_to);
    int n, cnt, prev, exp_pc;
    bit fin;
    if (ld) begin
      bus.load_en   = 1'b1;
      bus.load_addr = 4'(ld_a);
      bus.load_data = ld_d;
      prog[ld_a]    = ld_d;
    end
    n = 16;
    for (int i = 15; i >= 0; i--) if (prog[i][23:16] == HALT) n = i;
    if (exp_to) n = 0;
    exp_pc = (n == 16) ? 15 : n;
    bus.start      = 1'b1;
    bus.proc_ready = (mode == 0);
    cnt  = 0;
    prev = 0;
    fin  = 1'b0;
    while (!fin && cnt < BOUND) begin
      @(negedge clk);
      cnt++;
      bus.start   = 1'b0;
      bus.load_en = 1'b0;
      if (32'(bus.retired) != prev) begin
        chk("retire_step", 32'(bus.retired), prev + 1);
        chk("issue_word", {8'h0, bus.opcode, bus.operand1, bus.operand2}, {8'h0, prog[prev]});
        chk("retire_result", {20'h0, bus.last_flags, bus.last_result},
            {20'h0, flg_f(prog[prev]), res_f(prog[prev])});
        prev = prev + 1;
      end
      if (poke > 0 && cnt == poke + 1) begin
        chk("poke_pc", 32'(bus.pc), 0);
        chk("poke_retired", 32'(bus.retired), 0);
        chk("poke_busy", 32'(bus.busy), 1);
      end
      if (poke > 0 && cnt == poke) begin
        bus.start     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 4'd2;
        bus.load_data = 24'h0155AA;
      end
      case (mode)
        0:       bus.proc_ready = 1'b1;
        1:       bus.proc_ready = ($urandom_range(0, 3) != 0);
        2:       bus.proc_ready = (cnt >= 8);
        default: bus.proc_ready = 1'b0;
      endcase
      if (bus.done) fin = 1'b1;
    end
    if (!fin) begin
      chk("run_bound", 0, 1);
    end else begin
      if (n > 0) begin
        m_res = res_f(prog[n-1]);
        m_flg = flg_f(prog[n-1]);
        chk("hold_word", {8'h0, bus.opcode, bus.operand1, bus.operand2}, {8'h0, prog[n-1]});
      end
      if (exp_cyc > 0) chk("cycles", cnt, exp_cyc);
      chk("end_retired", 32'(bus.retired), n);
      chk("end_pc", 32'(bus.pc), exp_pc);
      chk("end_busy", 32'(bus.busy), 0);
      chk("end_timeout", 32'(bus.timeout_err), 32'(exp_to));
      chk("end_result", 32'(bus.last_result), 32'(m_res));
      chk("end_flags", 32'(bus.last_flags), 32'(m_flg));
    end
    bus.proc_ready = 1'b0;
  endtask

  typedef struct {
    logic [23:0] w [4];
    int          rtd;
    int          pcv;
    logic [7:0]  r;
    logic [3:0]  f;
    int          cyc;
  } vec_t;

  vec_t tv [4];

  initial begin
    bus.load_en    = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.proc_ready = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = {HALT, 16'h0};

    tv[0].w = '{24'h010503, 24'hFF0000, 24'hFF0000, 24'hFF0000};
    tv[0].rtd = 1; tv[0].pcv = 1; tv[0].r = 8'h08; tv[0].f = 4'h0; tv[0].cyc = 6;
    tv[1].w = '{24'h010A14, 24'h02F00F, 24'h833C3C, 24'hFF0000};
    tv[1].rtd = 3; tv[1].pcv = 3; tv[1].r = 8'h83; tv[1].f = 4'h6; tv[1].cyc = 14;
    tv[2].w = '{24'hFF0000, 24'h010203, 24'h010203, 24'h010203};
    tv[2].rtd = 0; tv[2].pcv = 0; tv[2].r = 8'h83; tv[2].f = 4'h6; tv[2].cyc = 2;
    tv[3].w = '{24'h0101FF, 24'h401234, 24'hFF0000, 24'h000000};
    tv[3].rtd = 2; tv[3].pcv = 2; tv[3].r = 8'h66; tv[3].f = 4'h1; tv[3].cyc = 10;

    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    @(negedge clk);

    // Directed program table, processor always ready.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) load_word(i, (i < 4) ? tv[t].w[i] : {HALT, 16'h0});
      run(0, 0, tv[t].cyc, 1'b0, 0, 24'h0, 1'b0);
      chk("tv_retired", 32'(bus.retired), tv[t].rtd);
      chk("tv_pc", 32'(bus.pc), tv[t].pcv);
      chk("tv_result", 32'(bus.last_result), 32'(tv[t].r));
      chk("tv_flags", 32'(bus.last_flags), 32'(tv[t].f));
      chk("tv_done", 32'(bus.done), 1);
    end

    // Full memory without HALT: stops at the last address, no wrap.
    for (int i = 0; i < 16; i++) load_word(i, {8'($urandom_range(0, 254)), 16'($urandom)});
    run(0, 0, 65, 1'b0, 0, 24'h0, 1'b0);

    // Write and start in the same cycle: the new HALT at 0 is what gets fetched.
    load_word(0, 24'h010503);
    load_word(1, {HALT, 16'h0});
    run(0, 0, 2, 1'b1, 0, {HALT, 16'h0}, 1'b0);

    // start/load_en pulsed during WAIT are ignored.
    load_word(0, 24'h010A14);
    load_word(1, 24'h02F00F);
    load_word(2, 24'h833C3C);
    load_word(3, {HALT, 16'h0});
    run(2, 3, 0, 1'b0, 0, 24'h0, 1'b0);

    // Reset during WAIT of the second instruction, then a clean rerun.
    bus.start      = 1'b1;
    bus.proc_ready = 1'b1;
    begin
      int c;
      c = 0;
      do begin
        @(negedge clk);
        bus.start = 1'b0;
        c++;
      end while (bus.retired != 5'd1 && c < 50);
      chk("pre_reset_retired", 32'(bus.retired), 1);
    end
    bus.proc_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_issue", {8'h0, bus.opcode, bus.operand1, bus.operand2}, {8'h0, prog[1]});
    reset = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    m_res = 8'h00;
    m_flg = 4'h0;
    @(negedge clk);
    run(1, 0, 0, 1'b0, 0, 24'h0, 1'b0);

`ifdef SEQ_TIMEOUT_EN
    // Processor never ready: abort after 15 WAIT cycles, nothing retired.
    run(3, 0, 17, 1'b0, 0, 24'h0, 1'b1);
`endif

    // Randomized programs with random processor latency.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 16; i++) begin
        if ((it % 4) != 0 && $urandom_range(0, 6) == 0)
          load_word(i, {HALT, 16'($urandom)});
        else
          load_word(i, {8'($urandom_range(0, 254)), 16'($urandom)});
      end
      run(1, 0, 0, 1'b0, 0, 24'h0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
